// File: rtl/sng_pkg.sv
// Shared types and reference math for the stochastic-number scheduler.
package sng_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM
    } sched_state_t;

    // Ones count of a BITSTREAM-long stream for signed quantized value q.
    function automatic int sng_count(input int q, input int quant, input int bitstream);
        int half;
        half = 1 << (quant - 1);
        return ((q + half) * bitstream + half) >>> quant;
    endfunction

endpackage

// File: rtl/SNG.sv
// Weyl-sequence stochastic number generator: sng_count(iData) ones placed at
// positions (BASE + STRIDE*i) mod BITSTREAM for i = 0, 1, 2, ...
module SNG
    import sng_pkg::*;
#(
    parameter int unsigned BITSTREAM = 64,
    parameter int unsigned BASE      = 2,
    parameter int unsigned STRIDE    = 17,
    parameter int unsigned QUANT     = 8
) (
    input  logic [QUANT-1:0]     iData,
    output logic [BITSTREAM-1:0] oBitstream
);

    localparam int unsigned PW = (BITSTREAM > 1) ? $clog2(BITSTREAM) : 1;

    int unsigned   ones;
    logic [PW-1:0] pos;

    always_comb begin
        oBitstream = '0;
        pos        = '0;
        ones       = unsigned'(sng_count(int'($signed(iData)), int'(QUANT), int'(BITSTREAM)));
        for (int unsigned i = 0; i < BITSTREAM; i++) begin
            pos = PW'((BASE + STRIDE * i) % BITSTREAM);
            if (i < ones) begin
                oBitstream[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sng_scheduler.sv
// Round-robin scheduler sharing one SNG among NREQ requesters; each grant
// becomes a serial BITSTREAM-bit stream tagged with the requester index.
module sng_scheduler
    import sng_pkg::*;
#(
    parameter int unsigned BITSTREAM = 64,
    parameter int unsigned BASE      = 2,
    parameter int unsigned STRIDE    = 17,
    parameter int unsigned QUANT     = 8,
    parameter int unsigned NREQ      = 4
) (
    input  logic                    iClk,
    input  logic                    iRst_n,
    input  logic [NREQ-1:0]         iReqValid,
    input  logic [NREQ*QUANT-1:0]   iReqData,
    output logic [NREQ-1:0]         oReqReady,
    output logic                    oBit,
    output logic                    oBitValid,
    input  logic                    iBitReady,
    output logic                    oBitLast,
    output logic [$clog2(NREQ)-1:0] oBitId,
    output logic                    oBusy
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(BITSTREAM);

    // Lowest requester at or above ptr wins; otherwise wrap to the lowest overall.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                input logic [IW-1:0]   ptr);
        logic [NREQ-1:0] masked;
        logic [NREQ-1:0] pool;
        masked = req & ({NREQ{1'b1}} << ptr);
        pool   = (|masked) ? masked : req;
        return pool & (~pool + NREQ'(1));
    endfunction

    function automatic logic [IW-1:0] onehot_idx(input logic [NREQ-1:0] oh);
        logic [IW-1:0] idx;
        idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (oh[k]) idx = IW'(k);
        end
        return idx;
    endfunction

    sched_state_t         state_q, state_d;
    logic [IW-1:0]        rr_q, id_q;
    logic [QUANT-1:0]     data_q;
    logic [BITSTREAM-1:0] sh_q, sng_bits;
    logic [CW-1:0]        cnt_q;
    logic [NREQ-1:0]      grant_c;
    logic [IW-1:0]        grant_idx;
    logic                 accept, bit_xfer, last;
    logic [QUANT-1:0]     lane_data [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_lane
        assign lane_data[k] = iReqData[k*QUANT +: QUANT];
    end

    assign grant_c   = rr_pick(iReqValid, rr_q);
    assign grant_idx = onehot_idx(grant_c);
    assign last      = (state_q == STREAM) && (cnt_q == CW'(BITSTREAM - 1));

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        bit_xfer = 1'b0;
        case (state_q)
            IDLE: begin
                if (|grant_c) begin
                    accept  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = STREAM;
            STREAM: begin
                if (iBitReady) begin
                    bit_xfer = 1'b1;
                    if (last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture on grant, load the SNG image after one settle cycle, then shift out by count.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rr_q   <= '0;
            id_q   <= '0;
            data_q <= '0;
            sh_q   <= '0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                data_q <= lane_data[grant_idx];
                id_q   <= grant_idx;
            end
            if (state_q == LOAD) begin
                sh_q  <= sng_bits;
                cnt_q <= '0;
            end
            if (bit_xfer) begin
                cnt_q <= cnt_q + CW'(1);
                if (last) begin
                    rr_q <= (id_q == IW'(NREQ - 1)) ? '0 : id_q + IW'(1);
                end
            end
        end
    end

    SNG #(
        .BITSTREAM (BITSTREAM),
        .BASE      (BASE),
        .STRIDE    (STRIDE),
        .QUANT     (QUANT)
    ) u_sng (
        .iData      (data_q),
        .oBitstream (sng_bits)
    );

    assign oReqReady = (state_q == IDLE) ? grant_c : '0;
    assign oBitValid = (state_q == STREAM);
    assign oBit      = oBitValid & sh_q[cnt_q];
    assign oBitLast  = last;
    assign oBitId    = oBitValid ? id_q : '0;
    assign oBusy     = (state_q != IDLE);

endmodule

// File: tb/tb_sng_scheduler.sv
// Bench for sng_scheduler: scoreboarded streams checked against the Weyl
// pattern, table-driven requests, grant order, backpressure and async reset.
module tb_sng_scheduler;
    import sng_pkg::*;

    localparam int unsigned BITSTREAM = 64;
    localparam int unsigned BASE      = 2;
    localparam int unsigned STRIDE    = 17;
    localparam int unsigned QUANT     = 8;
    localparam int unsigned NREQ      = 4;
    localparam int unsigned IW        = $clog2(NREQ);
    localparam int unsigned CW        = $clog2(BITSTREAM);
    localparam int          PERIOD    = BITSTREAM + 2;

    typedef struct {
        int lane;
        int q;
        int pop;
    } exp_t;

    logic                  iClk      = 1'b0;
    logic                  iRst_n    = 1'b0;
    logic [NREQ-1:0]       iReqValid = '0;
    logic [NREQ*QUANT-1:0] iReqData  = '0;
    logic                  iBitReady = 1'b1;
    logic [NREQ-1:0]       oReqReady;
    logic                  oBit, oBitValid, oBitLast, oBusy;
    logic [IW-1:0]         oBitId;

    sng_scheduler #(
        .BITSTREAM (BITSTREAM),
        .BASE      (BASE),
        .STRIDE    (STRIDE),
        .QUANT     (QUANT),
        .NREQ      (NREQ)
    ) dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iReqValid (iReqValid),
        .iReqData  (iReqData),
        .oReqReady (oReqReady),
        .oBit      (oBit),
        .oBitValid (oBitValid),
        .iBitReady (iBitReady),
        .oBitLast  (oBitLast),
        .oBitId    (oBitId),
        .oBusy     (oBusy)
    );

    always #5 iClk = ~iClk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   stall_mode = 1'b0;
    exp_t sb[$];

    always @(posedge iClk) cyc++;

    always @(posedge iClk) begin
        #1;
        iBitReady = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [BITSTREAM-1:0] weyl(input int s);
        logic [BITSTREAM-1:0] v;
        v = '0;
        for (int i = 0; i < s; i++) begin
            v[CW'((BASE + STRIDE * unsigned'(i)) % BITSTREAM)] = 1'b1;
        end
        return v;
    endfunction

    // Stream monitor: pops the scoreboard at each stream start.
    bit                   in_stream    = 1'b0;
    int                   mon_nbits    = 0;
    int                   streams_done = 0;
    int                   ones, last_bad;
    exp_t                 cur;
    logic [BITSTREAM-1:0] got;
    logic                 stalled = 1'b0;
    logic                 prev_bit, prev_last;
    logic [IW-1:0]        prev_id;

    always @(negedge iClk) begin
        if (!iRst_n) begin
            in_stream = 1'b0;
            stalled   = 1'b0;
            mon_nbits = 0;
        end else if (oBitValid) begin
            if (!in_stream) begin
                if (sb.size() == 0) begin
                    chk("unexpected_stream", 64'(1), 64'(0));
                    cur = '{-1, 0, 0};
                end else begin
                    cur = sb.pop_front();
                end
                chk("stream_id", 64'(oBitId), 64'(cur.lane));
                in_stream = 1'b1;
                mon_nbits = 0;
                got       = '0;
                ones      = 0;
                last_bad  = 0;
            end
            if (stalled) begin
                chk("stall_hold", 64'({oBit, oBitLast, oBitId}), 64'({prev_bit, prev_last, prev_id}));
            end
            if (iBitReady) begin
                got[CW'(mon_nbits)] = oBit;
                ones += int'(oBit);
                if (oBitLast != (mon_nbits == int'(BITSTREAM) - 1)) last_bad++;
                mon_nbits++;
                if (oBitLast || mon_nbits == int'(BITSTREAM)) begin
                    chk("stream_len", 64'(mon_nbits), 64'(BITSTREAM));
                    chk("last_flag", 64'(last_bad), 64'(0));
                    chk("popcount", 64'(ones), 64'(cur.pop));
                    chk("pattern", 64'(got), 64'(weyl(cur.pop)));
                    in_stream = 1'b0;
                    streams_done++;
                end
            end
            stalled   = !iBitReady;
            prev_bit  = oBit;
            prev_last = oBitLast;
            prev_id   = oBitId;
        end else begin
            if (in_stream) begin
                chk("valid_drop", 64'(1), 64'(0));
                in_stream = 1'b0;
            end
            stalled = 1'b0;
        end
    end

    task automatic await_grant(input int lane, input bit keep, output int gcyc);
        bit seen;
        seen = 1'b0;
        gcyc = -1;
        for (int t = 0; t < 1000 && !seen; t++) begin
            @(negedge iClk);
            if (|oReqReady) seen = 1'b1;
        end
        if (!seen) begin
            chk("grant_timeout", 64'(0), 64'(1));
            return;
        end
        chk("grant_onehot", 64'(oReqReady), 64'(1) << lane);
        gcyc = cyc;
        @(posedge iClk);
        #1;
        if (!keep) iReqValid[lane] = 1'b0;
        @(negedge iClk);
        chk("load_cycle", 64'({oReqReady, oBusy, oBitValid}), 64'({NREQ'(0), 1'b1, 1'b0}));
        @(negedge iClk);
        chk("first_bit", 64'({oBitValid, oBitId}), 64'({1'b1, IW'(lane)}));
    endtask

    task automatic issue(input int lane, input int q, input int pop);
        int g;
        @(posedge iClk);
        #1;
        iReqData[lane*QUANT +: QUANT] = QUANT'(q);
        iReqValid[lane] = 1'b1;
        sb.push_back('{lane, q, pop});
        await_grant(lane, 1'b0, g);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge iClk);
            if (sb.size() == 0 && !in_stream && !oBusy) done = 1'b1;
        end
        if (!done) chk("idle_timeout", 64'(0), 64'(1));
    endtask

    task automatic do_reset();
        @(negedge iClk);
        iRst_n = 1'b0;
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;
    endtask

    initial begin
        exp_t vecs[8];
        int   order[5];
        int   g, prev_g, expected_streams;
        bit   hit;

        vecs[0] = '{2,    0, 32};
        vecs[1] = '{0, -127,  0};
        vecs[2] = '{0,  127, 64};
        vecs[3] = '{3,   -1, 32};
        vecs[4] = '{1,    1, 32};
        vecs[5] = '{2,  100, 57};
        vecs[6] = '{3,  -64, 16};
        vecs[7] = '{1,   37, 41};
        order   = '{0, 1, 2, 3, 0};
        expected_streams = 0;

        // Reset state, and arbitration still visible while held in reset.
        #12;
        chk("reset_outputs", 64'({oBitValid, oBit, oBitLast, oBitId, oBusy, oReqReady}), 64'(0));
        iReqValid = 4'b0100;
        #1;
        chk("reset_arb", 64'(oReqReady), 64'(4'b0100));
        iReqValid = '0;
        @(negedge iClk);
        iRst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].lane, vecs[i].q, vecs[i].pop);
            wait_idle();
            expected_streams++;
        end

        stall_mode = 1'b1;
        issue(1, 37, 41);
        issue(3, -64, 16);
        wait_idle();
        stall_mode = 1'b0;
        expected_streams += 2;

        // All lanes valid at once from rr=0; lane 0 re-requests after its first grant.
        do_reset();
        @(posedge iClk);
        #1;
        for (int k = 0; k < 4; k++) begin
            iReqData[k*QUANT +: QUANT] = QUANT'(10 * (k + 1));
            sb.push_back('{k, 10 * (k + 1), sng_count(10 * (k + 1), QUANT, BITSTREAM)});
        end
        iReqValid = 4'b1111;
        prev_g = 0;
        for (int n = 0; n < 5; n++) begin
            await_grant(order[n], n == 0, g);
            if (n == 0) begin
                iReqData[0 +: QUANT] = QUANT'(-50);
                sb.push_back('{0, -50, sng_count(-50, QUANT, BITSTREAM)});
            end else begin
                chk("grant_spacing", 64'(g - prev_g), 64'(PERIOD));
            end
            prev_g = g;
        end
        iReqValid = '0;
        wait_idle();
        expected_streams += 5;

        // Mid-stream async reset: lane 2 stream abandoned, rr back to 0.
        issue(1, 20, sng_count(20, QUANT, BITSTREAM));
        wait_idle();
        expected_streams++;
        issue(2, 50, sng_count(50, QUANT, BITSTREAM));
        hit = 1'b0;
        for (int t = 0; t < 200 && !hit; t++) begin
            @(negedge iClk);
            if (mon_nbits >= 10) hit = 1'b1;
        end
        chk("reach_bit10", 64'(hit), 64'(1));
        #2;
        iRst_n = 1'b0;
        #1;
        chk("async_reset", 64'({oBitValid, oBit, oBitLast, oBitId, oBusy, oReqReady}), 64'(0));
        repeat (2) @(negedge iClk);
        #2;
        iRst_n = 1'b1;
        @(posedge iClk);
        #1;
        iReqData[1*QUANT +: QUANT] = QUANT'(-90);
        iReqData[3*QUANT +: QUANT] = QUANT'(90);
        iReqValid = 4'b1010;
        sb.push_back('{1, -90, sng_count(-90, QUANT, BITSTREAM)});
        await_grant(1, 1'b0, g);
        sb.push_back('{3, 90, sng_count(90, QUANT, BITSTREAM)});
        await_grant(3, 1'b0, g);
        wait_idle();
        expected_streams += 2;

        for (int q = -127; q <= 127; q++) begin
            issue((q + 127) % 4, q, sng_count(q, QUANT, BITSTREAM));
        end
        wait_idle();
        expected_streams += 255;

        chk("stream_count", 64'(streams_done), 64'(expected_streams));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
